// File: rtl/ct_l2c_sram_pkg.sv
// ---------------------------------------------------------------------------
// ct_l2c_sram_pkg
// Shared definitions for the L2C single-port SRAM controller:
//   - state_t : controller FSM state (INIT sweep / RUN service)
//   - rr_t    : which requester won the last contended arbitration
//   - DEF_*   : default address / data / tag widths for one 512x144 macro
// ---------------------------------------------------------------------------
package ct_l2c_sram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic {
      RR_RD = 1'b0,
      RR_WR = 1'b1
   } rr_t;

   localparam int unsigned DEF_ADDR_WIDTH = 9;
   localparam int unsigned DEF_DATA_WIDTH = 144;
   localparam int unsigned DEF_ID_WIDTH   = 4;

endpackage : ct_l2c_sram_pkg

// File: rtl/ct_l2c_sram_rd_pipe.sv
// ---------------------------------------------------------------------------
// ct_l2c_sram_rd_pipe
// Read-return pipeline: carries valid and tag RD_LAT cycles behind the read
// grant and presents the macro output alongside them.
//   forever_cpuclk / cpurst_b : clock, async active-low clear
//   rd_gnt, rd_id             : read accepted this cycle and its tag
//   sram_q                    : macro Q (valid the cycle after the access)
//   rd_vld, rd_id_out, rd_data: returned read; rd_data holds when idle
// RD_LAT = 1 passes Q straight through, RD_LAT = 2 registers it once.
// ---------------------------------------------------------------------------
module ct_l2c_sram_rd_pipe
   import ct_l2c_sram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
   parameter int          RD_LAT     = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  rd_gnt,
   input  logic [ID_WIDTH-1:0]   rd_id,
   input  logic [DATA_WIDTH-1:0] sram_q,
   output logic                  rd_vld,
   output logic [ID_WIDTH-1:0]   rd_id_out,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [RD_LAT-1:0] vld_sr;
   logic [ID_WIDTH-1:0] id_sr [RD_LAT];

   // NOTE: sequential state is written with <= so every stage samples the
   // value its predecessor held before the edge, giving a true shift.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         vld_sr <= '0;
         for (int i = 0; i < RD_LAT; i++) id_sr[i] <= '0;
      end else begin
         vld_sr[0] <= rd_gnt;
         if (rd_gnt) id_sr[0] <= rd_id;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            id_sr[i]  <= id_sr[i-1];
         end
      end
   end

   assign rd_vld    = vld_sr[RD_LAT-1];
   assign rd_id_out = id_sr[RD_LAT-1];

   // Q is only meaningful the cycle after a read access, so the data path
   // keeps the last returned word instead of following Q while idle.
   if (RD_LAT == 1) begin : g_pass
      logic [DATA_WIDTH-1:0] hold_q;

      // NOTE: this is a single data register, not a memory, so it is reset
      // to give rd_data a defined value before the first return.
      always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
         if (!cpurst_b)      hold_q <= '0;
         else if (vld_sr[0]) hold_q <= sram_q;
      end

      assign rd_data = vld_sr[0] ? sram_q : hold_q;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;

      always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
         if (!cpurst_b)      data_q <= '0;
         else if (vld_sr[0]) data_q <= sram_q;
      end

      assign rd_data = data_q;
   end

endmodule : ct_l2c_sram_rd_pipe

// File: rtl/ct_l2c_spsram_arb.sv
// ---------------------------------------------------------------------------
// ct_l2c_spsram_arb
// Controller for one 512x144 single-port L2C macro (A/CEN/GWEN/WEN/D/Q,
// active-low enables, 1-cycle read). After reset or init_req it zero-fills
// the whole array, then shares the port between one writer and one reader
// with round-robin arbitration. Reads return with their tag after RD_LAT.
//   forever_cpuclk / cpurst_b        : clock, async active-low reset
//   init_req / init_done             : re-run sweep / array ready
//   wr_req/addr/data/mask, wr_gnt    : write requester (mask active high)
//   rd_req/addr/id, rd_gnt           : read requester
//   rd_vld, rd_data, rd_id_out       : read return
//   sram_a/cen/gwen/wen/d, sram_q    : macro interface
// ---------------------------------------------------------------------------
module ct_l2c_spsram_arb
   import ct_l2c_sram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
   parameter int          RD_LAT     = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  init_req,
   output logic                  init_done,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_mask,
   output logic                  wr_gnt,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [ID_WIDTH-1:0]   rd_id,
   output logic                  rd_gnt,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ID_WIDTH-1:0]   rd_id_out,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

   state_t                state;
   rr_t                   rr_last;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic [ADDR_WIDTH-1:0] a_q;   // last address driven, held while idle
   logic [DATA_WIDTH-1:0] d_q;   // last data driven, held while idle

   assign init_done = (state == ST_RUN);

   // Grants and macro controls are decoded combinationally so the macro
   // samples them on the same edge that retires the request.
   always_comb begin
      // NOTE: every output gets a default first, so no branch can leave a
      // signal unassigned and infer a latch.
      wr_gnt    = 1'b0;
      rd_gnt    = 1'b0;
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = a_q;
      sram_d    = d_q;

      // The FSM already sits in INIT while reset is held; the macro must
      // still see a deselect then, so decoding waits for reset release.
      if (cpurst_b) begin
         if (state == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_d    = '0;
            sram_a    = init_cnt;
         end else if (!init_req) begin
            if (wr_req && rd_req) begin
               wr_gnt = (rr_last == RR_RD);
               rd_gnt = (rr_last == RR_WR);
            end else begin
               wr_gnt = wr_req;
               rd_gnt = rd_req;
            end

            if (wr_gnt) begin
               sram_cen  = 1'b0;
               sram_gwen = 1'b0;
               sram_wen  = ~wr_mask;
               sram_a    = wr_addr;
               sram_d    = wr_data;
            end else if (rd_gnt) begin
               sram_cen  = 1'b0;
               sram_a    = rd_addr;
            end
         end
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         rr_last  <= RR_RD;
         a_q      <= '0;
         d_q      <= '0;
      end else begin
         a_q <= sram_a;
         d_q <= sram_d;
         case (state)
            ST_INIT: begin
               // init_cnt wraps to 0 on its own after the last address.
               init_cnt <= init_cnt + CNT_ONE;
               if (init_cnt == '1) state <= ST_RUN;
            end
            ST_RUN: begin
               if (init_req) begin
                  state    <= ST_INIT;
                  init_cnt <= '0;
               end else if (wr_gnt) begin
                  rr_last <= RR_WR;
               end else if (rd_gnt) begin
                  rr_last <= RR_RD;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   ct_l2c_sram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .RD_LAT     (RD_LAT)
   ) u_rd_pipe (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .rd_gnt         (rd_gnt),
      .rd_id          (rd_id),
      .sram_q         (sram_q),
      .rd_vld         (rd_vld),
      .rd_id_out      (rd_id_out),
      .rd_data        (rd_data)
   );

endmodule : ct_l2c_spsram_arb

// File: tb/tb_ct_l2c_spsram_arb.sv
// ---------------------------------------------------------------------------
// tb_ct_l2c_spsram_arb
// Self-checking bench: a behavioural macro model answers the SRAM port, and
// a requester-level reference (flat array of expected contents, queue of
// expected read returns, remaining-sweep count, who-went-last flag) predicts
// every grant, macro control and read return.
// ---------------------------------------------------------------------------
module tb_ct_l2c_spsram_arb;

   localparam int AW     = 9;
   localparam int DW     = 144;
   localparam int IW     = 4;
   localparam int RD_LAT = 1;
   localparam int DEPTH  = 512;

   logic          clk;
   logic          rst_b;
   logic          init_req;
   logic          init_done;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] wr_mask;
   logic          wr_gnt;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic [IW-1:0] rd_id;
   logic          rd_gnt;
   logic          rd_vld;
   logic [DW-1:0] rd_data;
   logic [IW-1:0] rd_id_out;
   logic [AW-1:0] sram_a;
   logic          sram_cen;
   logic          sram_gwen;
   logic [DW-1:0] sram_wen;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;

   ct_l2c_spsram_arb #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW),
      .RD_LAT     (RD_LAT)
   ) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_b),
      .init_req       (init_req),
      .init_done      (init_done),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_mask        (wr_mask),
      .wr_gnt         (wr_gnt),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_id          (rd_id),
      .rd_gnt         (rd_gnt),
      .rd_vld         (rd_vld),
      .rd_data        (rd_data),
      .rd_id_out      (rd_id_out),
      .sram_a         (sram_a),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_wen       (sram_wen),
      .sram_d         (sram_d),
      .sram_q         (sram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural single-port macro ----------------
   logic [DW-1:0] macro_mem [DEPTH];
   logic          corrupt_en;
   logic [AW-1:0] corrupt_a;
   logic [DW-1:0] corrupt_d;

   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen)
            macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else
            sram_q <= macro_mem[sram_a];
      end else if (corrupt_en) begin
         macro_mem[corrupt_a] <= corrupt_d;
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } rd_exp_t;

   logic [DW-1:0] ref_mem [DEPTH];
   rd_exp_t       rq[$];
   int            n_checks;
   int            n_errors;
   int            cyc;
   int            sweep_left;
   bit            last_rd;
   logic [AW-1:0] exp_a;
   logic [DW-1:0] exp_d;
   logic [DW-1:0] last_rdata;
   bit            last_rvalid;

   logic          got_wr, got_rd, got_vld;
   logic [IW-1:0] got_id;
   logic [DW-1:0] got_data, got_wen;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < 5; k++) r = {r[DW-33:0], $urandom()};
      return r;
   endfunction

   task automatic clear_ref();
      foreach (ref_mem[i]) ref_mem[i] = '0;
   endtask

   // Offer new requests on idle requesters; a pending one stays untouched.
   task automatic arm(input int pw, input int pr, input int amax);
      if (!wr_req && $urandom_range(99) < pw) begin
         wr_req  = 1'b1;
         wr_addr = ($urandom_range(1) == 1) ? AW'($urandom_range(15)) : AW'($urandom_range(amax));
         wr_data = rand_data();
         wr_mask = ($urandom_range(3) == 0) ? '1 : rand_data();
      end
      if (!rd_req && $urandom_range(99) < pr) begin
         rd_req  = 1'b1;
         rd_addr = ($urandom_range(1) == 1) ? AW'($urandom_range(15)) : AW'($urandom_range(amax));
         rd_id   = IW'($urandom());
      end
   endtask

   // Called at a falling edge with inputs already driven; checks this
   // cycle, advances the model, and returns at the next falling edge.
   task automatic cycle();
      logic          exp_wg, exp_rg, exp_cen, exp_gwen, exp_vld;
      logic [DW-1:0] exp_wen;
      rd_exp_t       e;
      #1;
      exp_wg = 1'b0; exp_rg = 1'b0; exp_cen = 1'b1; exp_gwen = 1'b1; exp_wen = '1;
      if (sweep_left > 0) begin
         exp_cen = 1'b0; exp_gwen = 1'b0; exp_wen = '0;
         exp_a = AW'(DEPTH - sweep_left);
         exp_d = '0;
      end else if (!init_req) begin
         if (wr_req && rd_req) begin
            exp_wg = last_rd;
            exp_rg = !last_rd;
         end else begin
            exp_wg = wr_req;
            exp_rg = rd_req;
         end
         if (exp_wg) begin
            exp_cen = 1'b0; exp_gwen = 1'b0; exp_wen = ~wr_mask;
            exp_a = wr_addr; exp_d = wr_data;
         end else if (exp_rg) begin
            exp_cen = 1'b0;
            exp_a = rd_addr;
         end
      end
      check("init_done", DW'(init_done), DW'(sweep_left == 0));
      check("wr_gnt",    DW'(wr_gnt),    DW'(exp_wg));
      check("rd_gnt",    DW'(rd_gnt),    DW'(exp_rg));
      check("sram_cen",  DW'(sram_cen),  DW'(exp_cen));
      check("sram_gwen", DW'(sram_gwen), DW'(exp_gwen));
      check("sram_wen",  sram_wen,       exp_wen);
      check("sram_a",    DW'(sram_a),    DW'(exp_a));
      if (!exp_rg) check("sram_d", sram_d, exp_d);

      exp_vld = (rq.size() > 0) && (rq[0].due == cyc);
      check("rd_vld", DW'(rd_vld), DW'(exp_vld));
      if (exp_vld) begin
         e = rq.pop_front();
         check("rd_id_out", DW'(rd_id_out), DW'(e.id));
         check("rd_data",   rd_data,        e.data);
         last_rdata  = e.data;
         last_rvalid = 1'b1;
      end else if (last_rvalid) begin
         check("rd_data_hold", rd_data, last_rdata);
      end

      got_wr = wr_gnt; got_rd = rd_gnt; got_wen = sram_wen;
      got_vld = rd_vld; got_id = rd_id_out; got_data = rd_data;

      if (exp_wg) begin
         ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
         last_rd = 1'b0;
      end
      if (exp_rg) begin
         e.due = cyc + RD_LAT; e.id = rd_id; e.data = ref_mem[rd_addr];
         rq.push_back(e);
         last_rd = 1'b1;
      end
      if (sweep_left > 0) begin
         sweep_left--;
      end else if (init_req) begin
         sweep_left = DEPTH;
         clear_ref();
      end
      cyc++;
      @(negedge clk);
      if (exp_wg) wr_req = 1'b0;
      if (exp_rg) rd_req = 1'b0;
      init_req = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 12 && (wr_req || rd_req || rq.size() > 0); k++) cycle();
      check("drain_empty", DW'(rq.size()), '0);
   endtask

   task automatic check_reset_outputs();
      check("rst_init_done", DW'(init_done), '0);
      check("rst_wr_gnt",    DW'(wr_gnt),    '0);
      check("rst_rd_gnt",    DW'(rd_gnt),    '0);
      check("rst_rd_vld",    DW'(rd_vld),    '0);
      check("rst_rd_id_out", DW'(rd_id_out), '0);
      check("rst_sram_cen",  DW'(sram_cen),  DW'(1));
      check("rst_sram_gwen", DW'(sram_gwen), DW'(1));
      check("rst_sram_wen",  sram_wen,       '1);
      check("rst_sram_a",    DW'(sram_a),    '0);
      check("rst_sram_d",    sram_d,         '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] wd;
      n_checks = 0; n_errors = 0; cyc = 0;
      sweep_left = DEPTH; last_rd = 1'b1; exp_a = '0; exp_d = '0;
      last_rdata = '0; last_rvalid = 1'b0;
      clear_ref();
      corrupt_en = 1'b0; corrupt_a = '0; corrupt_d = '0;

      // Reset with both requesters active: nothing may reach the macro.
      rst_b = 1'b1; init_req = 1'b0;
      wr_req = 1'b1; wr_addr = 9'h1A5; wr_data = rand_data(); wr_mask = '1;
      rd_req = 1'b1; rd_addr = 9'h007; rd_id = 4'd2;
      #2 rst_b = 1'b0;
      #1 check_reset_outputs();

      // Scribble garbage into the macro so the sweep has something to clear.
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         corrupt_en = 1'b1;
         corrupt_a  = (k == 0) ? 9'h1A5 : (k == 1) ? 9'h007 : AW'($urandom());
         corrupt_d  = rand_data();
      end
      @(negedge clk);
      corrupt_en = 1'b0;
      check_reset_outputs();

      // First sweep, no requests; cycle 513 is the first RUN cycle.
      wr_req = 1'b0; rd_req = 1'b0;
      rst_b = 1'b1;
      for (int k = 0; k < DEPTH + 1; k++) cycle();

      // Full write then read-after-write of the same address.
      wd = rand_data(); wd[31:0] = 32'hDEADBEEF;
      wr_req = 1'b1; wr_addr = 9'h1A5; wr_data = wd; wr_mask = '1;
      cycle();
      check("raw_wr_gnt", DW'(got_wr), DW'(1));
      rd_req = 1'b1; rd_addr = 9'h1A5; rd_id = 4'd3;
      cycle();
      check("raw_rd_gnt", DW'(got_rd), DW'(1));
      cycle();
      check("raw_vld",  DW'(got_vld), DW'(1));
      check("raw_id",   DW'(got_id),  DW'(3));
      check("raw_data", got_data,     wd);

      // Partial write: only bits [15:0] enabled on a swept location.
      wr_req = 1'b1; wr_addr = 9'h007; wr_data = '1; wr_mask = DW'(16'hFFFF);
      cycle();
      check("part_wen", got_wen, {{(DW-16){1'b1}}, 16'h0000});
      rd_req = 1'b1; rd_addr = 9'h007; rd_id = 4'd9;
      cycle();
      cycle();
      check("part_vld",  DW'(got_vld), DW'(1));
      check("part_data", got_data,     DW'(16'hFFFF));

      // Both requesters held: last grant was a read, so write goes first.
      for (int i = 0; i < 6; i++) begin
         arm(100, 100, DEPTH - 1);
         cycle();
         check("alt_wr", DW'(got_wr), DW'(i % 2 == 0));
         check("alt_rd", DW'(got_rd), DW'(i % 2 == 1));
      end
      drain();

      // Random traffic over the whole array.
      for (int i = 0; i < 400; i++) begin
         arm(60, 60, DEPTH - 1);
         cycle();
      end
      drain();

      // init_req while a read is in flight; random traffic during the sweep
      // stays in the lower half so 0x1A5 is only touched by the sweep.
      rd_req = 1'b1; rd_addr = 9'h1A5; rd_id = 4'd5;
      cycle();
      init_req = 1'b1;
      arm(100, 100, 255);
      cycle();
      check("ini_vld",    DW'(got_vld), DW'(1));
      check("ini_id",     DW'(got_id),  DW'(5));
      check("ini_no_gnt", DW'({got_wr, got_rd}), '0);
      for (int i = 0; i < DEPTH; i++) begin
         arm(30, 30, 255);
         cycle();
      end
      drain();
      rd_req = 1'b1; rd_addr = 9'h1A5; rd_id = 4'd1;
      cycle();
      cycle();
      check("ini_zero_vld",  DW'(got_vld), DW'(1));
      check("ini_zero_data", got_data,     '0);

      // Async reset one cycle after a read grant: the read never returns.
      rd_req = 1'b1; rd_addr = AW'($urandom()); rd_id = 4'd6;
      #1 check("arst_rd_gnt", DW'(rd_gnt), DW'(1));
      @(posedge clk);
      #1 rst_b = 1'b0;
      #1 check_reset_outputs();
      rd_req = 1'b0;
      rq.delete();
      sweep_left = DEPTH; last_rd = 1'b1; exp_a = '0; exp_d = '0;
      last_rvalid = 1'b0;
      clear_ref();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("arst_hold_vld", DW'(rd_vld), '0);
      end
      rst_b = 1'b1;
      for (int i = 0; i < DEPTH + 40; i++) begin
         arm(40, 40, DEPTH - 1);
         cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_ct_l2c_spsram_arb
